// File: rtl/osiris_i_pkg.sv
// Shared constants and state encodings for the osiris_i UART-to-memory bridge.
package osiris_i_pkg;

  localparam logic [7:0] CMD_WRITE = 8'hAA;
  localparam logic [7:0] CMD_READ  = 8'h01;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DATA = 3'd2,
    WRITE    = 3'd3,
    READ     = 3'd4,
    SEND     = 3'd5
  } bridge_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } uart_rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/osiris_uart_wb_bridge.sv
// UART 8N1 receiver/transmitter plus the command FSM that turns byte streams into
// memory writes (and reads when OSIRIS_I_UART_READ_EN is defined).
module osiris_uart_wb_bridge #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 5208,
  parameter int IDX_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  input  logic                  start_rx,
  output logic                  uart_tx,
  output logic                  mem_we_o,
  output logic [IDX_W-1:0]      mem_idx_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o
`ifdef OSIRIS_I_UART_READ_EN
  ,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
`endif
);
  import osiris_i_pkg::CMD_WRITE;
  import osiris_i_pkg::CMD_READ;
  import osiris_i_pkg::bridge_state_t;
  import osiris_i_pkg::GET_ADDR;
  import osiris_i_pkg::GET_DATA;
  import osiris_i_pkg::WRITE;
  import osiris_i_pkg::READ;
  import osiris_i_pkg::SEND;
  import osiris_i_pkg::uart_rx_state_t;
  import osiris_i_pkg::RX_IDLE;
  import osiris_i_pkg::RX_START;
  import osiris_i_pkg::RX_DATA;
  import osiris_i_pkg::RX_STOP;

  localparam bridge_state_t IDLE = osiris_i_pkg::IDLE;

  localparam int CNT_W      = $clog2(CLKS_PER_BIT) + 1;
  localparam int ADDR_BYTES = ADDR_WIDTH / 8;
  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  // ---------------- receiver ----------------
  logic           rx_s1_q, rx_s2_q;
  uart_rx_state_t rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]     rx_bit_q, rx_bit_d;
  logic [7:0]     rx_shift_q, rx_shift_d;
  logic           rx_valid_q, rx_valid_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (start_rx && !rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_valid_d = rx_s2_q;  // low stop bit: framing error, byte dropped
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // ---------------- transmitter ----------------
  logic tx_go;
  logic tx_busy;
`ifdef OSIRIS_I_UART_READ_EN
  import osiris_i_pkg::uart_tx_state_t;
  import osiris_i_pkg::TX_IDLE;
  import osiris_i_pkg::TX_START;
  import osiris_i_pkg::TX_DATA;
  import osiris_i_pkg::TX_STOP;

  uart_tx_state_t   tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_out_q, tx_out_d;
  logic [DATA_WIDTH-1:0] tx_word_q, tx_word_d;

  assign tx_busy = (tx_state_q != TX_IDLE);
  assign uart_tx = tx_out_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_out_d   = tx_out_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_out_d = 1'b1;
        if (tx_go) begin
          tx_shift_d = tx_word_q[7:0];
          tx_out_d   = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_out_d   = tx_shift_q[0];
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_out_d   = 1'b1;
          tx_state_d = TX_STOP;
        end else begin
          tx_out_d   = tx_shift_q[1];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
        end
      end
      TX_STOP: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_out_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_out_q   <= tx_out_d;
    end
  end
`else
  assign tx_busy = 1'b0;
  assign uart_tx = 1'b1;
`endif

  // ---------------- command FSM ----------------
  bridge_state_t state, state_d;
  logic [2:0]            byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  is_read_q, is_read_d;

  always_comb begin
    state_d    = state;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    is_read_d  = is_read_q;
    mem_we_o   = 1'b0;
    tx_go      = 1'b0;
`ifdef OSIRIS_I_UART_READ_EN
    tx_word_d  = tx_word_q;
`endif
    unique case (state)
      IDLE: begin
        byte_cnt_d = '0;
        if (rx_valid_q) begin
          if (rx_shift_q == CMD_WRITE) begin
            state_d   = GET_ADDR;
            is_read_d = 1'b0;
          end
`ifdef OSIRIS_I_UART_READ_EN
          else if (rx_shift_q == CMD_READ) begin
            state_d   = GET_ADDR;
            is_read_d = 1'b1;
          end
`endif
        end
      end
      GET_ADDR: if (rx_valid_q) begin
        addr_d     = {rx_shift_q, addr_q[ADDR_WIDTH-1:8]};
        byte_cnt_d = byte_cnt_q + 3'd1;
        if (byte_cnt_q == 3'(ADDR_BYTES - 1)) begin
          byte_cnt_d = '0;
          state_d    = is_read_q ? READ : GET_DATA;
        end
      end
      GET_DATA: if (rx_valid_q) begin
        data_d     = {rx_shift_q, data_q[DATA_WIDTH-1:8]};
        byte_cnt_d = byte_cnt_q + 3'd1;
        if (byte_cnt_q == 3'(DATA_BYTES - 1)) begin
          byte_cnt_d = '0;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        mem_we_o = 1'b1;
        state_d  = IDLE;
      end
`ifdef OSIRIS_I_UART_READ_EN
      READ: begin
        tx_word_d  = mem_rdata_i;
        byte_cnt_d = '0;
        state_d    = SEND;
      end
      // The transmitter latches tx_word_q[7:0] on tx_go while the word shifts.
      SEND: if (!tx_busy) begin
        if (byte_cnt_q == 3'(DATA_BYTES)) begin
          state_d = IDLE;
        end else begin
          tx_go      = 1'b1;
          tx_word_d  = tx_word_q >> 8;
          byte_cnt_d = byte_cnt_q + 3'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      is_read_q  <= 1'b0;
`ifdef OSIRIS_I_UART_READ_EN
      tx_word_q  <= '0;
`endif
    end else begin
      state      <= state_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      is_read_q  <= is_read_d;
`ifdef OSIRIS_I_UART_READ_EN
      tx_word_q  <= tx_word_d;
`endif
    end
  end

  assign mem_idx_o   = addr_q[IDX_W+1:2];
  assign mem_wdata_o = data_q;

  wire unused_addr_bits = ^{addr_q[ADDR_WIDTH-1:IDX_W+2], addr_q[1:0], tx_busy};

endmodule

// File: rtl/osiris_i.sv
// UART-programmable instruction/data memory pair. Read-back over uart_tx exists only
// when OSIRIS_I_UART_READ_EN is defined; otherwise uart_tx is held high.
module osiris_i
  import osiris_i_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 50000000,
  parameter int MEM_DEPTH  = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic uart_rx,
  output logic uart_tx,
  input  logic select_mem,
  input  logic start_rx
);
  localparam int IDX_W        = $clog2(MEM_DEPTH);
  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;

  logic [DATA_WIDTH-1:0] imem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] dmem [MEM_DEPTH];

  logic                  mem_we;
  logic [IDX_W-1:0]      mem_idx;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Memories carry no reset so their contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (select_mem) dmem[mem_idx] <= mem_wdata;
      else            imem[mem_idx] <= mem_wdata;
    end
  end

`ifdef OSIRIS_I_UART_READ_EN
  logic [DATA_WIDTH-1:0] mem_rdata;
  assign mem_rdata = select_mem ? dmem[mem_idx] : imem[mem_idx];
`endif

  osiris_uart_wb_bridge #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .IDX_W       (IDX_W)
  ) U_UART_WB_BRIDGE (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .start_rx   (start_rx),
    .uart_tx    (uart_tx),
    .mem_we_o   (mem_we),
    .mem_idx_o  (mem_idx),
    .mem_wdata_o(mem_wdata)
`ifdef OSIRIS_I_UART_READ_EN
    ,
    .mem_rdata_i(mem_rdata)
`endif
  );

endmodule

// File: tb/tb_osiris_i.sv
// Randomised bench for osiris_i against a word-array model of both memories.
module tb_osiris_i;
  import osiris_i_pkg::*;

  localparam int CLOCK_FREQ = 1_000_000;
  localparam int BAUD       = 100_000;
  localparam int CPB        = CLOCK_FREQ / BAUD;
  localparam int DEPTH      = 256;

  logic clk = 1'b0;
  logic rst, uart_rx, select_mem, start_rx;
  logic uart_tx;

  always #5 clk = ~clk;

  osiris_i #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .BAUD_RATE(BAUD),
    .CLOCK_FREQ(CLOCK_FREQ), .MEM_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .select_mem(select_mem), .start_rx(start_rx)
  );

  int checks = 0;
  int errors = 0;
  int tx_low_cnt = 0;

  logic [31:0] m_mem [2][DEPTH];
  bit          m_vld [2][DEPTH];

  always @(negedge clk) if (rst && uart_tx !== 1'b1) tx_low_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input bit sel, input int idx);
    return sel ? dut.dmem[idx] : dut.imem[idx];
  endfunction

  function automatic int widx(input logic [31:0] addr);
    return int'((addr / 4) % DEPTH);
  endfunction

  task automatic check_idle(input string tag);
    check(tag, 32'(dut.U_UART_WB_BRIDGE.state), 32'(IDLE));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop = 1'b1);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = good_stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic do_write(input bit sel, input logic [31:0] addr, input logic [31:0] data);
    select_mem = sel;
    send_byte(CMD_WRITE);
    send_word(addr);
    send_word(data);
    repeat (4) @(negedge clk);
    if (start_rx) begin
      m_mem[sel][widx(addr)] = data;
      m_vld[sel][widx(addr)] = 1'b1;
    end
  endtask

  task automatic send_read_cmd(input bit sel, input logic [31:0] addr);
    select_mem = sel;
    send_byte(CMD_READ);
    send_word(addr);
  endtask

`ifdef OSIRIS_I_UART_READ_EN
  task automatic recv_byte(output logic [7:0] b, output bit ok);
    int t = 0;
    b  = '0;
    ok = 1'b1;
    while (uart_tx === 1'b1 && t < 1200) begin
      @(negedge clk);
      t++;
    end
    if (uart_tx === 1'b1) begin
      ok = 1'b0;
      return;
    end
    repeat (CPB / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = uart_tx;
    end
    repeat (CPB) @(negedge clk);
    if (uart_tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic do_read(input string tag, input bit sel, input logic [31:0] addr);
    logic [31:0] exp;
    exp = m_mem[sel][widx(addr)];
    fork
      send_read_cmd(sel, addr);
      begin
        logic [7:0] b;
        bit ok;
        for (int k = 0; k < 4; k++) begin
          recv_byte(b, ok);
          check({tag, "_frame"}, 32'(ok), 32'd1);
          check({tag, "_byte"}, 32'(b), 32'(exp[8*k +: 8]));
        end
      end
    join
    repeat (4) @(negedge clk);
    check_idle({tag, "_idle"});
  endtask
`endif

  initial begin
    logic [31:0] a, d;
    bit s;
    rst = 1'b0; uart_rx = 1'b1; select_mem = 1'b0; start_rx = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_tx", 32'(uart_tx), 32'd1);
    check_idle("reset_state");
    rst = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      do_write(1'b0, 32'(4 * i), 32'h93 + 32'(i));
      check($sformatf("imem_w%0d", i), mem_word(1'b0, i), m_mem[0][i]);
      check_idle("idle_after_write");
    end

`ifdef OSIRIS_I_UART_READ_EN
    do_read("rd_addr8", 1'b0, 32'h8);
`else
    tx_low_cnt = 0;
    send_read_cmd(1'b0, 32'h8);
    repeat (40) @(negedge clk);
    check("tx_idle_no_read", 32'(tx_low_cnt), 32'd0);
    check_idle("idle_after_unknown_read");
`endif

    do_write(1'b1, 32'h0, 32'hA5A5A5A5);
    check("dmem_w0", mem_word(1'b1, 0), 32'hA5A5A5A5);
`ifdef OSIRIS_I_UART_READ_EN
    do_read("rd_dmem0", 1'b1, 32'h0);
`endif
    check("imem_w0_kept", mem_word(1'b0, 0), 32'h93);

    // unknown command byte, then write wrapping to word 1
    send_byte(8'h55);
    check_idle("idle_after_55");
    do_write(1'b0, 32'h404, 32'h12345678);
    check("wrap_w1", mem_word(1'b0, 1), 32'h12345678);

    // reset after 4 of 9 bytes
    select_mem = 1'b0;
    send_byte(CMD_WRITE);
    send_byte(8'h0C); send_byte(8'h00); send_byte(8'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("tx_in_reset", 32'(uart_tx), 32'd1);
    check_idle("idle_in_reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    do_write(1'b0, 32'h20, 32'hCAFEF00D);
    check("post_reset_write", mem_word(1'b0, 8), 32'hCAFEF00D);
    check("no_partial_write", mem_word(1'b0, 3), m_mem[0][3]);

    // receiver disabled
    start_rx = 1'b0;
    do_write(1'b0, 32'h0, 32'hDEADBEEF);
    check("start_rx_off_mem", mem_word(1'b0, 0), m_mem[0][0]);
    check_idle("start_rx_off_idle");
    start_rx = 1'b1;

    // start glitch then framing error: both must leave the FSM untouched
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_byte(CMD_WRITE, 1'b0);
    check_idle("idle_after_bad_stop");
    do_write(1'b1, 32'h10, 32'h0BADF00D);
    check("after_glitch_write", mem_word(1'b1, 4), 32'h0BADF00D);

    for (int n = 0; n < 10; n++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      d = $urandom;
      do_write(s, a, d);
      check($sformatf("rand_w%0d", n), mem_word(s, widx(a)), m_mem[s][widx(a)]);
`ifdef OSIRIS_I_UART_READ_EN
      if (n % 3 == 0) do_read($sformatf("rand_rd%0d", n), s, a);
`endif
    end

    for (int m = 0; m < 2; m++)
      for (int i = 0; i < DEPTH; i++)
        if (m_vld[m][i]) check($sformatf("final_m%0d_w%0d", m, i), mem_word(m[0], i), m_mem[m][i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
